// File: rtl/dl_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dl_shift_pipe
// Description : Two-stage elastic shifter (SLL/SRL/SRA). Operand register,
//               then result register. Every shift uses one left shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_shift_pipe #(
    parameter int NUM_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BITS-1:0]         in_data,
    input  logic [$clog2(NUM_BITS)-1:0] in_shamt,
    input  logic [1:0]                  in_op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_BITS-1:0]         out_data
);

    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);
    localparam logic [NUM_BITS-1:0] c_all_ones = '1;

    logic                      r_s1_valid;
    logic [NUM_BITS-1:0]       r_s1_data;
    logic [NUM_SHIFT_BITS-1:0] r_s1_shamt;
    logic [1:0]                r_s1_op;
    logic                      r_out_valid;
    logic [NUM_BITS-1:0]       r_out_data;

    logic                w_s2_free;
    logic                w_accept;
    logic                w_is_right;
    logic                w_is_arith;
    logic [NUM_BITS-1:0] w_pre;
    logic [NUM_BITS-1:0] w_shl;
    logic [NUM_BITS-1:0] w_shl_rev;
    logic [NUM_BITS-1:0] w_mask;
    logic [NUM_BITS-1:0] w_mask_rev;
    logic [NUM_BITS-1:0] w_result;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !flush && (!r_s1_valid || w_s2_free);
    assign w_accept  = in_valid && in_ready;

    // Right shifts reuse the left shifter by reversing bits before and after.
    // The reserved op 10 has op[0]=0 and therefore falls through to SLL.
    assign w_is_right = r_s1_op[0];
    assign w_is_arith = (r_s1_op == 2'b11);
    assign w_shl      = w_pre << r_s1_shamt;
    assign w_mask     = c_all_ones << r_s1_shamt;

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_rev
        assign w_pre[i]      = w_is_right ? r_s1_data[NUM_BITS-1-i] : r_s1_data[i];
        assign w_shl_rev[i]  = w_shl[NUM_BITS-1-i];
        assign w_mask_rev[i] = w_mask[NUM_BITS-1-i];
    end

    // ~w_mask_rev marks exactly the vacated MSB positions of a right shift.
    assign w_result = !w_is_right ? w_shl :
                      (w_shl_rev | ((w_is_arith && r_s1_data[NUM_BITS-1]) ? ~w_mask_rev : '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_shamt  <= '0;
            r_s1_op     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_s2_free) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_result;
                end
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_shamt <= in_shamt;
                r_s1_op    <= in_op;
            end else if (r_s1_valid && w_s2_free) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_dl_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl_shift_pipe
// Description : Directed and random checks of dl_shift_pipe against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_shift_pipe;

    localparam int NB = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_data;
    logic [4:0]    in_shamt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] out_data;

    dl_shift_pipe #(.NUM_BITS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [NB-1:0] q[$];        // in-flight results, oldest first
    logic          head_out;    // oldest in-flight result is on the output
    logic          acc_flag;
    logic [NB-1:0] emitted[$];
    int            emit_cyc[$];

    function automatic logic [NB-1:0] ref_shift(logic [NB-1:0] d, logic [4:0] sh, logic [1:0] op);
        logic signed [NB-1:0] s;
        s = d;
        case (op)
            2'b01:   return d >> sh;
            2'b11:   return s >>> sh;
            default: return d << sh;
        endcase
    endfunction

    task automatic check(string tag, logic [NB-1:0] obs, logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called with clk low and inputs applied; returns at the next falling edge.
    task automatic cycle();
        logic          exp_ready;
        logic          do_drain;
        logic          had_s1;
        logic          s2_free;
        logic [NB-1:0] res;
        #1;
        exp_ready = !flush && (q.size() < 2 || out_ready);
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, head_out);
        if (head_out) check("out_data", out_data, q[0]);
        acc_flag = in_valid && exp_ready;
        do_drain = head_out && out_ready && !flush;
        res      = ref_shift(in_data, in_shamt, in_op);
        if (out_valid && out_ready && !flush) begin
            emitted.push_back(out_data);
            emit_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (flush) begin
            q.delete();
            head_out = 1'b0;
        end else begin
            had_s1  = q.size() > (head_out ? 1 : 0);
            s2_free = !head_out || out_ready;
            if (do_drain) void'(q.pop_front());
            if (s2_free) head_out = had_s1;
            if (acc_flag) q.push_back(res);
        end
        @(negedge clk);
    endtask

    task automatic send(logic [NB-1:0] d, logic [4:0] sh, logic [1:0] op);
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (n) cycle();
    endtask

    int b;
    int idx;
    logic [NB-1:0] vals[3];

    initial begin
        head_out = 1'b0;
        acc_flag = 1'b0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single SLL, two-edge latency
        send(32'h0000_0001, 5'd31, 2'b00);
        check("lat_edge1", out_valid, 1'b0);
        cycle();
        check("lat_edge2", out_valid, 1'b1);
        check("sll31", out_data, 32'h8000_0000);
        idle(2);

        // SRL then SRA of a negative operand
        b = emitted.size();
        send(32'h8000_0000, 5'd4, 2'b01);
        send(32'h8000_0000, 5'd4, 2'b11);
        idle(4);
        check("srl4", emitted[b], 32'h0800_0000);
        check("sra4", emitted[b+1], 32'hF800_0000);

        // shamt=0 identity and SRA by NB-1
        b = emitted.size();
        send(32'hA5C3_0F96, 5'd0, 2'b00);
        send(32'hA5C3_0F96, 5'd0, 2'b01);
        send(32'hA5C3_0F96, 5'd0, 2'b11);
        send(32'h8000_0001, 5'd31, 2'b11);
        send(32'h7FFF_FFFF, 5'd31, 2'b11);
        idle(4);
        for (int i = 0; i < 3; i++) check("shamt0", emitted[b+i], 32'hA5C3_0F96);
        check("sra31_neg", emitted[b+3], 32'hFFFF_FFFF);
        check("sra31_pos", emitted[b+4], 32'h0000_0000);

        // Back-to-back stream
        b = emitted.size();
        for (int i = 0; i < 8; i++) send(32'h1, 5'(i), 2'b00);
        idle(4);
        check("stream_count", 32'(emitted.size() - b), 32'd8);
        for (int i = 0; i < 8; i++) check("stream_data", emitted[b+i], 32'h1 << i);
        check("stream_consec", 32'(emit_cyc[b+7] - emit_cyc[b]), 32'd7);

        // Output stall with three offered ops
        b = emitted.size();
        vals[0] = 32'h2; vals[1] = 32'h4; vals[2] = 32'h8;
        idx = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'(idx + 1); in_op = 2'b00;
            cycle();
            if (acc_flag) idx++;
        end
        check("stall_accepted", 32'(idx), 32'd2);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_data", out_data, vals[0]);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && idx < 3; k++) begin
            in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'(idx + 1); in_op = 2'b00;
            cycle();
            if (acc_flag) idx++;
        end
        check("stall_third", 32'(idx), 32'd3);
        idle(5);
        for (int i = 0; i < 3; i++) check("stall_order", emitted[b+i], vals[i]);

        // Flush with both stages occupied
        out_ready = 1'b0;
        send(32'h1111_1111, 5'd1, 2'b00);
        send(32'h2222_2222, 5'd1, 2'b00);
        b = emitted.size();
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5; in_shamt = 5'd0; in_op = 2'b00;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        send(32'h0000_0003, 5'd4, 2'b00);
        idle(4);
        check("flush_count", 32'(emitted.size() - b), 32'd1);
        check("flush_next", emitted[b], 32'h0000_0030);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd2, 2'b01);
        send(32'h9ABC_DEF0, 5'd3, 2'b11);
        b = emitted.size();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_data", out_data, '0);
        check("arst_in_ready", in_ready, 1'b1);
        q.delete();
        head_out = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h0000_0003, 5'd2, 2'b10);
        idle(4);
        check("arst_count", 32'(emitted.size() - b), 32'd1);
        check("op10_sll", emitted[b], 32'h0000_000C);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_op     = 2'($urandom_range(0, 3));
            cycle();
        end
        idle(4);
        check("final_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dl_shift_pipe.md
DL_SHIFT_PIPE -- requirements
Module: dl_shift_pipe

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have localparam NUM_SHIFT_BITS, equal to $clog2(NUM_BITS), the shift-amount width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous kill of all in-flight operations.
REQ-006 SHALL have port in_valid, input, 1, upstream operation present.
REQ-007 SHALL have port in_ready, output, 1, block accepts operation this cycle.
REQ-008 SHALL have port in_data, input, NUM_BITS, operand to shift.
REQ-009 SHALL have port in_shamt, input, NUM_SHIFT_BITS, shift amount.
REQ-010 SHALL have port in_op, input, 2, 00=SLL, 01=SRL, 11=SRA, 10=reserved.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port out_data, output, NUM_BITS, shift result.

Function
REQ-014 SHALL be a two-stage elastic pipeline: S1 = operand register; S2 = result register driving out_data.
REQ-015 SHALL accept an operation on any rising edge where in_valid && in_ready are both high.
REQ-016 SHALL capture in_data, in_shamt and in_op into S1 on acceptance and set s1_valid.
REQ-017 SHALL compute the S1→S2 result combinationally with one left-shift datapath:
- SLL: data << shamt.
- SRL: bit-reverse data, left-shift, bit-reverse result.
- SRA: as SRL, with vacated MSBs filled by data[NUM_BITS-1].
REQ-018 SHALL treat in_op=10 exactly as SLL.
REQ-019 SHALL advance S1 into S2 when s1_valid && (!out_valid || out_ready).
REQ-020 SHALL drive in_ready = !s1_valid || (!out_valid || out_ready); this combinational out_ready→in_ready path is permitted.
REQ-021 SHALL assert out_valid on the cycle after S1 advances; latency from acceptance edge N to out_valid is 2 edges (visible after edge N+1).
REQ-022 SHALL sustain one operation per cycle when out_ready is held high.
REQ-023 SHALL hold out_data and out_valid stable while out_valid && !out_ready (no drop, no change).
REQ-024 SHALL hold S1 contents while S1 is stalled.
REQ-025 SHALL clear out_valid on a handshake edge when S1 has nothing to advance.
REQ-026 SHALL handle a simultaneous S2 drain, S1 advance and new acceptance on one edge with no loss or duplication.
REQ-027 SHALL produce shamt=0 results equal to data for every op.
REQ-028 SHALL produce SRA with shamt=NUM_BITS-1 results of all copies of the sign bit.
REQ-029 SHALL, when flush=1 at an edge, clear s1_valid and out_valid and accept nothing that cycle; in_ready SHALL be 0 while flush=1.
REQ-030 SHALL give flush priority over all handshakes on the same edge.

Reset
REQ-031 SHALL, on rst_n low, immediately and asynchronously clear s1_valid and out_valid, and clear the S1 registers and out_data to 0.
REQ-032 SHALL drive in_ready=1 while rst_n is low and after release, with flush low.
REQ-033 SHALL discard any operation in flight when reset asserts mid-operation; it SHALL never appear on the output.
REQ-034 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL verify: reset, then one SLL with data=0x0000_0001, shamt=31, out_ready=1 -> out_valid after 2 edges, out_data=0x8000_0000.
REQ-036 SHALL verify: SRL data=0x8000_0000, shamt=4, then SRA same operands -> 0x0800_0000, then 0xF800_0000.
REQ-037 SHALL verify: back-to-back stream of 8 SLL ops, data=1, shamt=0..7, out_ready=1 -> 8 consecutive out_valid cycles, 0x01,0x02,...,0x80 in order.
REQ-038 SHALL verify: out_ready=0 for 5 cycles while 3 ops are offered -> exactly 2 accepted, in_ready=0 thereafter, out_data stable; on out_ready=1 the 2 results drain in order, then the 3rd op is accepted.
REQ-039 SHALL verify: flush pulse with S1 and S2 both valid -> out_valid=0 next cycle, neither result ever emitted, next accepted op returns correctly.
REQ-040 SHALL verify: rst_n low asynchronously mid-stall -> out_valid=0 before the next clock edge, out_data=0; op=10 with data=0x3, shamt=2 -> 0xC.
